// File: rtl/mips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_pkg : forwarding select codes, hazard FSM states, register width
// Rev 1.0
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int NB_REG = 5;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;

  localparam int         STATE_W  = 1;
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/forward_select.sv
`default_nettype none
// ---------------------------------------------------------------------------
// forward_select : compare/priority for one execute-stage operand
// Rev 1.0
// ---------------------------------------------------------------------------
module forward_select #(
  parameter int NB_REG = mips_pkg::NB_REG
) (
  input  logic [NB_REG-1:0] src_i,
  input  logic              src_used_i,
  input  logic              ex_mem_wr_i,
  input  logic [NB_REG-1:0] ex_mem_dest_i,
  input  logic              mem_wb_wr_i,
  input  logic [NB_REG-1:0] mem_wb_dest_i,
  output logic [1:0]        sel_o
);
  import mips_pkg::*;

  // The younger producer (EX/MEM) wins; $0 is never forwarded.
  always_comb begin
    sel_o = FWD_REG;
    if (src_used_i && ex_mem_wr_i && (ex_mem_dest_i == src_i) && (ex_mem_dest_i != '0)) begin
      sel_o = FWD_EX_MEM;
    end else if (src_used_i && mem_wb_wr_i && (mem_wb_dest_i == src_i) && (mem_wb_dest_i != '0)) begin
      sel_o = FWD_MEM_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// forward_unit : operand forwarding selects and load-use stall generation
// Rev 1.0
// ---------------------------------------------------------------------------
module forward_unit #(
  parameter int NB_REG = mips_pkg::NB_REG,
  parameter int NB_CNT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              id_valid_i,
  input  logic [NB_REG-1:0] id_rs_i,
  input  logic [NB_REG-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic [NB_REG-1:0] ex_write_reg_i,
  input  logic              flush_i,
  output logic [1:0]        forward_signal_regA,
  output logic [1:0]        forward_signal_regB,
  output logic              stall_o,
  output logic [NB_CNT-1:0] stall_count_o
);
  import mips_pkg::*;

  logic              idex_valid_q,     idex_valid_d;
  logic [NB_REG-1:0] idex_rs_q,        idex_rs_d;
  logic [NB_REG-1:0] idex_rt_q,        idex_rt_d;
  logic              idex_uses_rt_q,   idex_uses_rt_d;
  logic              idex_reg_write_q, idex_reg_write_d;
  logic              idex_mem_read_q,  idex_mem_read_d;
  logic [NB_REG-1:0] exmem_dest_q,     exmem_dest_d;
  logic              exmem_wr_q,       exmem_wr_d;
  logic [NB_REG-1:0] memwb_dest_q,     memwb_dest_d;
  logic              memwb_wr_q,       memwb_wr_d;
  logic [STATE_W-1:0] state_q,         state_d;
  logic [NB_CNT-1:0] stall_cnt_q,      stall_cnt_d;
  logic              hazard;
  logic              bubble;

  // The load sitting in ID/EX resolves its destination in EX this cycle.
  assign hazard = idex_valid_q & idex_mem_read_q & (ex_write_reg_i != '0) & id_valid_i &
                  ((ex_write_reg_i == id_rs_i) | (id_uses_rt_i & (ex_write_reg_i == id_rt_i)));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN:   state_d = (hazard && !flush_i) ? ST_STALL : ST_RUN;
      ST_STALL: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_o = (state_q == ST_RUN) & hazard & ~flush_i;
  end

  always_comb begin
    bubble           = stall_o | flush_i;
    idex_valid_d     = bubble ? 1'b0 : id_valid_i;
    idex_rs_d        = bubble ? '0   : id_rs_i;
    idex_rt_d        = bubble ? '0   : id_rt_i;
    idex_uses_rt_d   = bubble ? 1'b0 : id_uses_rt_i;
    idex_reg_write_d = bubble ? 1'b0 : id_reg_write_i;
    idex_mem_read_d  = bubble ? 1'b0 : id_mem_read_i;
    exmem_dest_d     = ex_write_reg_i;
    exmem_wr_d       = idex_valid_q & idex_reg_write_q;
    memwb_dest_d     = exmem_dest_q;
    memwb_wr_d       = exmem_wr_q;
    stall_cnt_d      = (stall_o && (stall_cnt_q != '1)) ? stall_cnt_q + NB_CNT'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idex_valid_q     <= 1'b0;
      idex_rs_q        <= '0;
      idex_rt_q        <= '0;
      idex_uses_rt_q   <= 1'b0;
      idex_reg_write_q <= 1'b0;
      idex_mem_read_q  <= 1'b0;
      exmem_dest_q     <= '0;
      exmem_wr_q       <= 1'b0;
      memwb_dest_q     <= '0;
      memwb_wr_q       <= 1'b0;
      stall_cnt_q      <= '0;
    end else begin
      idex_valid_q     <= idex_valid_d;
      idex_rs_q        <= idex_rs_d;
      idex_rt_q        <= idex_rt_d;
      idex_uses_rt_q   <= idex_uses_rt_d;
      idex_reg_write_q <= idex_reg_write_d;
      idex_mem_read_q  <= idex_mem_read_d;
      exmem_dest_q     <= exmem_dest_d;
      exmem_wr_q       <= exmem_wr_d;
      memwb_dest_q     <= memwb_dest_d;
      memwb_wr_q       <= memwb_wr_d;
      stall_cnt_q      <= stall_cnt_d;
    end
  end

  assign stall_count_o = stall_cnt_q;

  forward_select #(.NB_REG(NB_REG)) u_sel_a (
    .src_i         (idex_rs_q),
    .src_used_i    (1'b1),
    .ex_mem_wr_i   (exmem_wr_q),
    .ex_mem_dest_i (exmem_dest_q),
    .mem_wb_wr_i   (memwb_wr_q),
    .mem_wb_dest_i (memwb_dest_q),
    .sel_o         (forward_signal_regA)
  );

  forward_select #(.NB_REG(NB_REG)) u_sel_b (
    .src_i         (idex_rt_q),
    .src_used_i    (idex_uses_rt_q),
    .ex_mem_wr_i   (exmem_wr_q),
    .ex_mem_dest_i (exmem_dest_q),
    .mem_wb_wr_i   (memwb_wr_q),
    .mem_wb_dest_i (memwb_dest_q),
    .sel_o         (forward_signal_regB)
  );

endmodule
`default_nettype wire

// File: tb/tb_forward_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_forward_unit : directed and randomized checks of forward_unit
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_forward_unit;
  localparam int NB_REG  = 5;
  localparam int NB_CNT  = 4;
  localparam int CNT_MAX = (1 << NB_CNT) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid, id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [NB_REG-1:0] id_rs, id_rt, ex_write_reg;
  logic [1:0]        sel_a, sel_b;
  logic              stall;
  logic [NB_CNT-1:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  forward_unit #(.NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .id_valid_i          (id_valid),
    .id_rs_i             (id_rs),
    .id_rt_i             (id_rt),
    .id_uses_rt_i        (id_uses_rt),
    .id_reg_write_i      (id_reg_write),
    .id_mem_read_i       (id_mem_read),
    .ex_write_reg_i      (ex_write_reg),
    .flush_i             (flush),
    .forward_signal_regA (sel_a),
    .forward_signal_regB (sel_b),
    .stall_o             (stall),
    .stall_count_o       (stall_count)
  );

  // Reference model: the last three instructions to enter EX, youngest first.
  typedef struct packed {
    logic              valid;
    logic [NB_REG-1:0] rs, rt, dest;
    logic              uses_rt, rw, mr;
  } ins_t;

  ins_t hist [3];
  logic stalled_last;
  int   m_cnt;

  task automatic m_reset();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    stalled_last = 1'b0;
    m_cnt = 0;
  endtask

  function automatic logic [1:0] m_sel(logic [NB_REG-1:0] src, logic used);
    for (int age = 1; age <= 2; age++) begin
      if (used && hist[age].valid && hist[age].rw && hist[age].dest == src && src != 0)
        return (age == 1) ? 2'b01 : 2'b10;
    end
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    logic haz;
    haz = hist[0].valid && hist[0].mr && ex_write_reg != 0 && id_valid &&
          (ex_write_reg == id_rs || (id_uses_rt && ex_write_reg == id_rt));
    return haz && !flush && !stalled_last;
  endfunction

  task automatic issue(input logic v, input int rs, input int rt, input logic ur,
                       input logic rw, input logic mr, input int exd, input logic fl);
    id_valid     = v;
    id_rs        = NB_REG'(rs);
    id_rt        = NB_REG'(rt);
    id_uses_rt   = ur;
    id_reg_write = rw;
    id_mem_read  = mr;
    ex_write_reg = NB_REG'(exd);
    flush        = fl;
    #2;
  endtask

  task automatic tick();
    logic s;
    ins_t n;
    s = m_stall();
    n = '0;
    if (!(s || flush)) begin
      n.valid = id_valid; n.rs = id_rs; n.rt = id_rt;
      n.uses_rt = id_uses_rt; n.rw = id_reg_write; n.mr = id_mem_read;
    end
    hist[0].dest = ex_write_reg;
    @(posedge clk);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = n;
    stalled_last = s;
    if (s && m_cnt < CNT_MAX) m_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    issue(1, 3, 3, 1, 1, 1, 3, 0);
    repeat (2) @(negedge clk);
    #2;
    n_cmp++; if (sel_a !== 2'b00) begin n_bad++; $display("FAIL reset_regA: got %b want 00", sel_a); end
    n_cmp++; if (sel_b !== 2'b00) begin n_bad++; $display("FAIL reset_regB: got %b want 00", sel_b); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (stall_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", stall_count); end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fwd_distance();
    issue(1, 1, 2, 1, 1, 0, 0, 0); tick();
    issue(1, 3, 4, 1, 1, 0, 3, 0);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: got %b want 0", stall); end
    tick();
    issue(0, 0, 0, 0, 0, 0, 8, 0);
    n_cmp++; if (sel_a !== 2'b01) begin n_bad++; $display("FAIL b2b_regA: got %b want 01", sel_a); end
    tick();
    issue(1, 1, 2, 1, 1, 0, 0, 0); tick();
    issue(0, 0, 0, 0, 0, 0, 3, 0); tick();
    issue(1, 3, 4, 1, 1, 0, 0, 0);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL gap1_stall: got %b want 0", stall); end
    tick();
    issue(0, 0, 0, 0, 0, 0, 8, 0);
    n_cmp++; if (sel_a !== 2'b10) begin n_bad++; $display("FAIL gap1_regA: got %b want 10", sel_a); end
    n_cmp++; if (sel_b !== 2'b00) begin n_bad++; $display("FAIL gap1_regB: got %b want 00", sel_b); end
    tick();
  endtask

  task automatic test_load_use();
    issue(1, 1, 0, 0, 1, 1, 0, 0); tick();
    issue(1, 2, 5, 1, 1, 0, 5, 0);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", stall); end
    tick();
    issue(1, 2, 5, 1, 1, 0, 0, 0);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_2nd: got %b want 0", stall); end
    tick();
    issue(0, 0, 0, 0, 0, 0, 6, 0);
    n_cmp++; if (sel_b !== 2'b10) begin n_bad++; $display("FAIL lu_regB: got %b want 10", sel_b); end
    n_cmp++; if (sel_a !== 2'b00) begin n_bad++; $display("FAIL lu_regA: got %b want 00", sel_a); end
    n_cmp++; if (stall_count !== NB_CNT'(1)) begin n_bad++; $display("FAIL lu_count: got %0d want 1", stall_count); end
    tick();
  endtask

  task automatic test_zero_reg();
    issue(1, 1, 2, 1, 1, 0, 0, 0); tick();
    issue(1, 0, 0, 1, 1, 0, 0, 0); tick();
    issue(0, 0, 0, 0, 0, 0, 4, 0);
    n_cmp++; if (sel_a !== 2'b00) begin n_bad++; $display("FAIL zero_regA: got %b want 00", sel_a); end
    n_cmp++; if (sel_b !== 2'b00) begin n_bad++; $display("FAIL zero_regB: got %b want 00", sel_b); end
    tick();
    issue(1, 1, 0, 0, 1, 1, 0, 0); tick();
    issue(1, 0, 0, 1, 1, 0, 0, 0);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL zero_lw_stall: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_priority();
    issue(1, 1, 2, 0, 1, 0, 0, 0); tick();
    issue(1, 3, 4, 0, 1, 0, 7, 0); tick();
    issue(1, 7, 7, 1, 1, 0, 7, 0); tick();
    issue(0, 0, 0, 0, 0, 0, 1, 0);
    n_cmp++; if (sel_a !== 2'b01) begin n_bad++; $display("FAIL prio_regA: got %b want 01", sel_a); end
    n_cmp++; if (sel_b !== 2'b01) begin n_bad++; $display("FAIL prio_regB: got %b want 01", sel_b); end
    tick();
  endtask

  task automatic test_flush();
    issue(1, 1, 5, 0, 1, 1, 6, 0); tick();
    issue(1, 5, 2, 1, 1, 0, 5, 1);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", stall); end
    tick();
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (sel_a !== 2'b00) begin n_bad++; $display("FAIL flush_regA: got %b want 00", sel_a); end
    n_cmp++; if (sel_b !== 2'b00) begin n_bad++; $display("FAIL flush_regB: got %b want 00", sel_b); end
    n_cmp++; if (stall_count !== NB_CNT'(1)) begin n_bad++; $display("FAIL flush_count: got %0d want 1", stall_count); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      issue(($urandom % 4) != 0, $urandom % 8, $urandom % 8, $urandom % 2,
            $urandom % 2, ($urandom % 3) == 0, $urandom % 8, ($urandom % 10) == 0);
      n_cmp++; if (sel_a !== m_sel(hist[0].rs, 1'b1)) begin n_bad++;
        $display("FAIL rnd_regA c=%0d: got %b want %b", c, sel_a, m_sel(hist[0].rs, 1'b1)); end
      n_cmp++; if (sel_b !== m_sel(hist[0].rt, hist[0].uses_rt)) begin n_bad++;
        $display("FAIL rnd_regB c=%0d: got %b want %b", c, sel_b, m_sel(hist[0].rt, hist[0].uses_rt)); end
      n_cmp++; if (stall !== m_stall()) begin n_bad++;
        $display("FAIL rnd_stall c=%0d: got %b want %b", c, stall, m_stall()); end
      n_cmp++; if (stall_count !== NB_CNT'(m_cnt)) begin n_bad++;
        $display("FAIL rnd_count c=%0d: got %0d want %0d", c, stall_count, m_cnt); end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    issue(1, 1, 0, 0, 1, 1, 0, 0); tick();
    issue(1, 2, 5, 1, 1, 0, 5, 0);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mid_stall_pre: got %b want 1", stall); end
    tick();
    issue(1, 2, 5, 1, 1, 0, 0, 0);
    n_cmp++; if (stall_count !== NB_CNT'(m_cnt)) begin n_bad++;
      $display("FAIL mid_count_pre: got %0d want %0d", stall_count, m_cnt); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (stall_count !== '0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", stall_count); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mid_rst_stall: got %b want 0", stall); end
    n_cmp++; if (sel_a !== 2'b00 || sel_b !== 2'b00) begin n_bad++;
      $display("FAIL mid_rst_sel: got %b/%b want 00/00", sel_a, sel_b); end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= CNT_MAX + 2; k++) begin
      issue(1, 1, 0, 0, 1, 1, 9, 0); tick();
      issue(1, 2, 5, 1, 1, 0, 5, 0);
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sat_stall k=%0d: got %b want 1", k, stall); end
      tick();
      issue(1, 2, 5, 1, 1, 0, 0, 0); tick();
      if (k == CNT_MAX) begin
        n_cmp++; if (stall_count !== NB_CNT'(CNT_MAX)) begin n_bad++;
          $display("FAIL sat_reach: got %0d want %0d", stall_count, CNT_MAX); end
      end
    end
    n_cmp++; if (stall_count !== NB_CNT'(CNT_MAX)) begin n_bad++;
      $display("FAIL sat_hold: got %0d want %0d", stall_count, CNT_MAX); end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_fwd_distance();
    test_load_use();
    test_zero_reg();
    test_priority();
    test_flush();
    test_random();
    test_reset_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
